// File: rtl/pmem_burst_adapter.sv
// pmem_burst_adapter: memory-side responder for the 256-bit cacheline port.
// A line read or write is split into a 4 x 64-bit burst, and completion is
// signalled with a one-cycle line_resp_o pulse.
// Optional feature: define PMEM_TIMEOUT_EN to enable a per-beat watchdog that
// aborts a stalled burst after TIMEOUT_CYCLES idle cycles and raises a sticky err_o.
//
// state    | meaning
// IDLE     | waiting for line_read_i / line_write_i (read wins)
// RD_BURST | collecting read beats from memory
// WR_BURST | presenting write beats to memory
// DONE     | one-cycle line_resp_o, beat counter cleared
module pmem_burst_adapter #(
  parameter int BEATS          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read_i,
  input  logic         line_write_i,
  input  logic [31:0]  line_addr_i,
  input  logic [255:0] line_wdata_i,
  output logic [255:0] line_rdata_o,
  output logic         line_resp_o,
  output logic [31:0]  burst_addr_o,
  output logic         burst_read_o,
  output logic         burst_write_o,
  output logic [63:0]  burst_wdata_o,
  input  logic [63:0]  burst_rdata_i,
  input  logic         burst_resp_i,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  if (BEATS != 4) begin : g_bad_beats
    $error("pmem_burst_adapter: only BEATS=4 is supported");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("pmem_burst_adapter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t       state_q, state_d;
  logic [1:0]   beat_q;
  logic [1:0]   next_beat;
  logic [255:0] wr_line_q;
  logic [255:0] rd_line_q;
  logic [255:0] rd_merged;
  logic         in_burst;
  logic         beat_ok;
  logic         last_beat;
  logic         timeout;
  logic         addr_offset_unused;

  // byte offset within the line has no meaning on a line-aligned burst
  assign addr_offset_unused = ^line_addr_i[4:0];

  assign in_burst    = (state_q == RD_BURST) || (state_q == WR_BURST);
  assign beat_ok     = in_burst && burst_resp_i;
  assign last_beat   = beat_ok && (beat_q == LAST_BEAT);
  assign next_beat   = beat_q + 2'd1;
  assign line_resp_o = (state_q == DONE);

  // partially assembled read line with the current beat dropped into its slot
  always_comb begin
    rd_merged = rd_line_q;
    rd_merged[{beat_q, 6'd0} +: 64] = burst_rdata_i;
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (line_read_i) begin
          state_d = RD_BURST;
        end else if (line_write_i) begin
          state_d = WR_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (last_beat || timeout) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // burst request outputs, beat counter and line buffers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q        <= 2'd0;
      burst_addr_o  <= 32'd0;
      burst_read_o  <= 1'b0;
      burst_write_o <= 1'b0;
      burst_wdata_o <= 64'd0;
      wr_line_q     <= 256'd0;
      rd_line_q     <= 256'd0;
      line_rdata_o  <= 256'd0;
    end else begin
      case (state_q)
        IDLE: begin
          beat_q <= 2'd0;
          if (line_read_i) begin
            burst_addr_o <= {line_addr_i[31:5], 5'd0};
            burst_read_o <= 1'b1;
          end else if (line_write_i) begin
            burst_addr_o  <= {line_addr_i[31:5], 5'd0};
            burst_write_o <= 1'b1;
            wr_line_q     <= line_wdata_i;
            burst_wdata_o <= line_wdata_i[63:0];
          end
        end
        RD_BURST: begin
          if (beat_ok) begin
            rd_line_q <= rd_merged;
            beat_q    <= next_beat;
          end
          // an aborted burst returns whatever beats have arrived so far
          if (last_beat || timeout) begin
            burst_read_o <= 1'b0;
            line_rdata_o <= beat_ok ? rd_merged : rd_line_q;
          end
        end
        WR_BURST: begin
          if (beat_ok) begin
            beat_q        <= next_beat;
            burst_wdata_o <= wr_line_q[{next_beat, 6'd0} +: 64];
          end
          if (last_beat || timeout) begin
            burst_write_o <= 1'b0;
          end
        end
        DONE: begin
          beat_q <= 2'd0;
        end
        default: begin
          beat_q <= 2'd0;
        end
      endcase
    end
  end

`ifdef PMEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign timeout = in_burst && !burst_resp_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign err_o   = err_q;

  // idle-cycle watchdog, restarted by burst start and by every accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (in_burst && !burst_resp_i) begin
        wd_q <= wd_q + 1'b1;
      end else begin
        wd_q <= '0;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Bench for pmem_burst_adapter: directed scenarios plus randomized line
// traffic, compared every cycle against a transaction-level reference.
module tb_pmem_burst_adapter;

`ifdef PMEM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  localparam logic [255:0] PAT_LINE = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
  localparam logic [255:0] W2_LINE  = {{8{8'hD3}}, {8{8'hD2}}, {8{8'hD1}}, {8{8'hD0}}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_read_i = 1'b0;
  logic         line_write_i = 1'b0;
  logic [31:0]  line_addr_i = '0;
  logic [255:0] line_wdata_i = '0;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  burst_addr_o;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i = '0;
  logic         burst_resp_i = 1'b0;
  logic         err_o;

  always #5 clk = ~clk;

  pmem_burst_adapter #(.BEATS(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .line_read_i   (line_read_i),
    .line_write_i  (line_write_i),
    .line_addr_i   (line_addr_i),
    .line_wdata_i  (line_wdata_i),
    .line_rdata_o  (line_rdata_o),
    .line_resp_o   (line_resp_o),
    .burst_addr_o  (burst_addr_o),
    .burst_read_o  (burst_read_o),
    .burst_write_o (burst_write_o),
    .burst_wdata_o (burst_wdata_o),
    .burst_rdata_i (burst_rdata_i),
    .burst_resp_i  (burst_resp_i),
    .err_o         (err_o)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] wq[$];
  bit saw_wr = 0;

  // Reference: which line transaction is open, how many beats it has seen,
  // and what the requester should observe.
  int           m_mode = 0;   // 0 none, 1 read, 2 write
  int           m_got = 0;
  int           m_idle = 0;
  bit           m_resp = 0;
  bit           m_err = 0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_wline = '0;
  logic [255:0] m_rline = '0;
  logic [255:0] m_rdata = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_got = 0; m_idle = 0; m_resp = 0; m_err = 0;
      m_addr = '0; m_wline = '0; m_rline = '0; m_rdata = '0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_mode == 0) begin
      if (line_read_i) begin
        m_mode = 1; m_got = 0; m_idle = 0;
        m_addr = {line_addr_i[31:5], 5'd0};
      end else if (line_write_i) begin
        m_mode = 2; m_got = 0; m_idle = 0;
        m_addr = {line_addr_i[31:5], 5'd0};
        m_wline = line_wdata_i;
      end
    end else if (burst_resp_i) begin
      if (m_mode == 1) m_rline[m_got*64 +: 64] = burst_rdata_i;
      m_got++;
      m_idle = 0;
      if (m_got == 4) begin
        if (m_mode == 1) m_rdata = m_rline;
        m_mode = 0;
        m_resp = 1;
      end
    end else begin
      m_idle++;
`ifdef PMEM_TIMEOUT_EN
      if (m_idle == TO) begin
        if (m_mode == 1) m_rdata = m_rline;
        m_mode = 0;
        m_resp = 1;
        m_err = 1;
      end
`endif
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance to the next falling edge and compare every output with the reference
  task automatic step();
    @(negedge clk);
    check("line_resp", line_resp_o, m_resp);
    check("burst_read", burst_read_o, m_mode == 1);
    check("burst_write", burst_write_o, m_mode == 2);
    check("burst_addr", burst_addr_o, m_addr);
    check("line_rdata", line_rdata_o, m_rdata);
    check("err", err_o, m_err);
    if (m_mode == 2) check("burst_wdata", burst_wdata_o, m_wline[m_got*64 +: 64]);
  endtask

  // present one line request and act as memory until line_resp_o
  // period: 0 = random beat acceptance, n = accept when cycle count is a multiple of n
  // pat: read beats carry 0x11.., 0x22.., ... in beat order
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd, input int period, input bit pat,
                         input bit hold, output int lat);
    int n;
    int beat;
    bit done;
    n = 0; beat = 0; done = 0; lat = -1;
    wq.delete();
    line_read_i = rd; line_write_i = wr; line_addr_i = addr; line_wdata_i = wd;
    burst_resp_i = 1'b0;
    while (!done && n < 200) begin
      step();
      n++;
      if (burst_write_o) saw_wr = 1;
      if (line_resp_o) begin
        done = 1;
        lat = n;
        burst_resp_i = 1'b0;
        if (!hold) begin
          line_read_i = 1'b0;
          line_write_i = 1'b0;
        end
      end else begin
        if (period == 0) burst_resp_i = 1'($urandom_range(0, 1));
        else burst_resp_i = ((n % period) == 0);
        burst_rdata_i = pat ? {8{8'(17 * (beat + 1))}} : {$urandom, $urandom};
        if (burst_resp_i && (burst_read_o || burst_write_o)) begin
          if (burst_write_o) wq.push_back(burst_wdata_o);
          beat++;
        end
      end
    end
    if (!done) check("txn_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [63:0] d2 [4];
    d2 = '{64'hD0D0_D0D0_D0D0_D0D0, 64'hD1D1_D1D1_D1D1_D1D1,
           64'hD2D2_D2D2_D2D2_D2D2, 64'hD3D3_D3D3_D3D3_D3D3};

    repeat (2) @(negedge clk);
    check("rst_line_resp", line_resp_o, 1'b0);
    check("rst_burst_read", burst_read_o, 1'b0);
    check("rst_burst_write", burst_write_o, 1'b0);
    check("rst_burst_addr", burst_addr_o, 32'd0);
    check("rst_line_rdata", line_rdata_o, 256'd0);
    check("rst_burst_wdata", burst_wdata_o, 64'd0);
    check("rst_err", err_o, 1'b0);
    rst = 1'b0;
    step();

    // zero-wait read
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1, 1'b1, 1'b0, lat);
    check("t1_latency", lat, 5);
    check("t1_addr", burst_addr_o, 32'h0000_1220);
    check("t1_rdata", line_rdata_o, PAT_LINE);
    check("t1_read_low", burst_read_o, 1'b0);

    // write with memory accepting every third cycle
    step();
    run_txn(1'b0, 1'b1, 32'h8000_0040, W2_LINE, 3, 1'b0, 1'b0, lat);
    check("t2_latency", lat, 13);
    check("t2_addr", burst_addr_o, 32'h8000_0040);
    check("t2_beats", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) check("t2_wdata", wq[i], d2[i]);
    step();
    check("t2_no_second_resp", line_resp_o, 1'b0);
    check("t2_write_low", burst_write_o, 1'b0);

    // read and write together: read wins
    step();
    saw_wr = 0;
    run_txn(1'b1, 1'b1, 32'h1357_9BDF, {8{32'hCAFE_F00D}}, 2, 1'b0, 1'b0, lat);
    check("t3_no_write", saw_wr, 1'b0);
    check("t3_latency", lat, 9);
    check("t3_addr", burst_addr_o, 32'h1357_9BC0);

    // reset in the middle of a read burst
    step();
    line_read_i = 1'b1; line_addr_i = 32'h0000_2000; burst_resp_i = 1'b0;
    step();
    burst_resp_i = 1'b1; burst_rdata_i = {4{16'hAAAA}};
    step();
    burst_rdata_i = {4{16'hBBBB}};
    step();
    burst_resp_i = 1'b0;
    check("t4_pre_read", burst_read_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_read", burst_read_o, 1'b0);
    check("t4_rst_addr", burst_addr_o, 32'd0);
    check("t4_rst_rdata", line_rdata_o, 256'd0);
    check("t4_rst_resp", line_resp_o, 1'b0);
    line_read_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("t4_no_resp", line_resp_o, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1, 1'b1, 1'b0, lat);
    check("t4_latency", lat, 5);
    check("t4_rdata", line_rdata_o, PAT_LINE);

    // back-to-back reads with the request held through the response
    step();
    run_txn(1'b1, 1'b0, 32'h0000_3000, '0, 1, 1'b0, 1'b1, lat);
    n = 0;
    while (n < 10 && !burst_read_o) begin
      step();
      n++;
    end
    check("t5_gap", n, 2);
    run_txn(1'b1, 1'b0, 32'h0000_3000, '0, 1, 1'b1, 1'b0, lat);
    check("t5_rdata", line_rdata_o, PAT_LINE);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      bit rd;
      bit wr;
      bit hold;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) wr = 1'b1;
      hold = ($urandom_range(0, 3) == 0);
      run_txn(rd, wr, $urandom, {8{$urandom}}, 0, 1'b0, hold, lat);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          burst_resp_i = 1'($urandom_range(0, 1));
          step();
        end
        burst_resp_i = 1'b0;
      end
    end

`ifdef PMEM_TIMEOUT_EN
    // memory never answers: watchdog aborts the burst
    step();
    run_txn(1'b1, 1'b0, 32'h0000_4000, '0, 1000, 1'b0, 1'b0, lat);
    check("to_latency", lat, 9);
    check("to_err", err_o, 1'b1);
    repeat (3) step();
    check("to_err_sticky", err_o, 1'b1);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_burst_adapter.md
Name: pmem_burst_adapter

Overview:
- Memory-side responder for the 256-bit cacheline interface driven by the L1 caches (pmem_read / pmem_write / pmem_resp / pmem_address / pmem_rdata / pmem_wdata).
- Accepts one full-line read or write request and converts it into a 4-beat × 64-bit burst transaction on the physical-memory bus.
- Returns the assembled line, or the write completion, with a single-cycle response pulse.
- Sits between the cache (or arbiter) and main memory.

Parameters:
- BEATS, 4, beats per line; fixed at 4 (256/64); other values unsupported.
- TIMEOUT_CYCLES, 255, watchdog limit per beat; used only with PMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- line_read_i  in  1  line read request from cache (pmem_read).
- line_write_i  in  1  line write request from cache (pmem_write).
- line_addr_i  in  32  line address (pmem_address).
- line_wdata_i  in  256  line to write (pmem_wdata).
- line_rdata_o  out  256  assembled read line (pmem_rdata).
- line_resp_o  out  1  one-cycle completion pulse (pmem_resp).
- burst_addr_o  out  32  line-aligned burst address, bits [4:0] = 0.
- burst_read_o  out  1  burst read request.
- burst_write_o  out  1  burst write request.
- burst_wdata_o  out  64  current write beat.
- burst_rdata_i  in  64  current read beat.
- burst_resp_i  in  1  beat accepted/valid this cycle.
- err_o  out  1  timeout flag (tied 0 without PMEM_TIMEOUT_EN).

Behaviour:
- Reset (asynchronous, any state): state=IDLE, beat counter=0. All outputs 0, including line_rdata_o. No partial line is ever returned after reset.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - line_read_i=1 → latch line_addr_i; go to RD_BURST.
  - else line_write_i=1 → latch line_addr_i and line_wdata_i; go to WR_BURST.
  - Both asserted → read wins; write is ignored until re-presented.
- Output timing: burst_read_o, burst_write_o and burst_addr_o are registered. They assert the cycle after acceptance and hold steady for the whole burst. burst_addr_o = {latched_addr[31:5], 5'b0}.
- RD_BURST:
  - Each cycle with burst_resp_i=1: store burst_rdata_i into line bits [64k+63:64k], k = beat counter (0..3); increment counter.
  - On the beat with k=3: go to DONE; deassert burst_read_o next cycle.
- WR_BURST:
  - burst_wdata_o = latched line bits [64k+63:64k].
  - Each burst_resp_i=1 advances k; on k=3 go to DONE.
  - burst_wdata_o updates in the cycle after each accepted beat.
- DONE: line_resp_o=1 for exactly one cycle; counter cleared; next state IDLE.
  - line_rdata_o holds the assembled line from DONE until the next read completes.
- Requester holds its request and operands until line_resp_o. A request still high in the IDLE cycle after DONE is treated as a new request.
- burst_resp_i in IDLE or DONE: ignored.
- Counter wraps 3→0 only through DONE.
- Minimum latency with zero-wait memory: accept at cycle 0, beats at cycles 1–4, line_resp_o at cycle 5.

Optional Feature:
- Macro: PMEM_TIMEOUT_EN.
- With the macro:
  - A counter resets on every accepted beat and on burst start.
  - If it reaches TIMEOUT_CYCLES in RD_BURST or WR_BURST: go to DONE, pulse line_resp_o, and set err_o.
  - err_o is sticky until reset. A partial read line is returned unmodified for unreceived beats.
- Without the macro: no watchdog; err_o is constant 0; a burst waits indefinitely.

Test Plan:
- Read, zero-wait: line_read_i=1, addr 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → burst_addr_o=0x0000_1220; line_resp_o at cycle 5; line_rdata_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with wait states: line_write_i=1, addr 0x8000_0040, line={D3,D2,D1,D0}; burst_resp_i every 3rd cycle → burst_wdata_o shows D0, D1, D2, D3 in order; exactly one line_resp_o after the 4th accept; burst_write_o low afterwards.
- Simultaneous line_read_i=1 and line_write_i=1 in IDLE → burst_read_o=1, burst_write_o stays 0 throughout.
- Assert rst after the 2nd read beat → all outputs 0 immediately; no line_resp_o; a new read then completes normally with counter starting at beat 0.
- Back-to-back: read held high through the response cycle → second burst_read_o asserts 2 cycles after line_resp_o.
- PMEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no burst_resp_i → line_resp_o pulses 9 cycles after burst start; err_o=1 and stays 1.
